// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE output packer.
package rle_pkg;

  localparam int          RLE_W       = 16;
  localparam int          RLE_CNT_BIT = 15;
  localparam logic [15:0] RLE_PAD     = 16'h8000;  // run count 0, discarded by the decoder

  // Packed 32-bit output word: first word of the pair in the low half.
  typedef struct packed {
    logic [RLE_W-1:0] word1;
    logic [RLE_W-1:0] word0;
  } packed_word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  function automatic packed_word_t make_pair(input logic [RLE_W-1:0] w0,
                                             input logic [RLE_W-1:0] w1);
    packed_word_t p;
    p.word0 = w0;
    p.word1 = w1;
    return p;
  endfunction

endpackage

// File: rtl/rle_pack_fifo.sv
// First-word-fall-through FIFO for packed RLE words.
// The caller only asserts push when there is room (or a pop happens in the same
// cycle) and only asserts pop when the FIFO is not empty.
module rle_pack_fifo
  import rle_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         core_clk,
  input  logic         core_rst_n,
  input  logic         push,
  input  packed_word_t wdata,
  input  logic         pop,
  output packed_word_t rdata,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  level
);

  packed_word_t mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  // Pointer and occupancy next-state; pointers wrap naturally modulo DEPTH.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!core_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge core_clk) begin
    // NOTE: the array is not reset; empty/level gate every read, so its contents never escape.
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/rle_pack.sv
// Packs the 16-bit RLE stream into 32-bit words (first word low), buffers them in
// a FWFT FIFO, pads a half-pair on flush and flags lost words instead of stalling.
// Optional feature: define RLE_PACK_STATS_EN for the saturating drop_cnt counter.
module rle_pack
  import rle_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         core_clk,
  input  logic         core_rst_n,
  input  logic [15:0]  rle_data,
  input  logic         rle_valid,
  input  logic         flush,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [AW:0]  level,
  output logic         overflow,
  output logic         flush_done
`ifdef RLE_PACK_STATS_EN
  ,
  output logic [15:0]  drop_cnt
`endif
);

  logic [15:0]  half_q, half_d;
  logic         half_vld_q, half_vld_d;
  logic         overflow_q, overflow_d;
  logic         flush_done_q, flush_done_d;
  state_e       state_q, state_d;

  logic         push_req, push_en, drop, pop;
  packed_word_t push_word, fifo_rdata;
  logic         fifo_empty, fifo_full;
  logic [AW:0]  fifo_level;

  rle_pack_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .push       (push_en),
    .wdata      (push_word),
    .pop        (pop),
    .rdata      (fifo_rdata),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .level      (fifo_level)
  );

  assign pop = !fifo_empty && out_ready;

  // Pairing, flush padding, push acceptance and flush FSM next-state.
  always_comb begin
    half_d     = half_q;
    half_vld_d = half_vld_q;
    push_req   = 1'b0;
    push_word  = '0;
    state_d    = state_q;

    // A new word is always taken before any pad decision.
    if (rle_valid) begin
      if (half_vld_q) begin
        push_req   = 1'b1;
        push_word  = make_pair(half_q, rle_data);
        half_vld_d = 1'b0;
      end else if (flush) begin
        push_req  = 1'b1;
        push_word = make_pair(rle_data, RLE_PAD);
      end else begin
        half_d     = rle_data;
        half_vld_d = 1'b1;
      end
    end else if (flush && half_vld_q) begin
      push_req   = 1'b1;
      push_word  = make_pair(half_q, RLE_PAD);
      half_vld_d = 1'b0;
    end

    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_en    = push_req && (!fifo_full || pop);
    drop       = push_req && !push_en;
    overflow_d = overflow_q || drop;

    case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
      FLUSH:   if (!flush && fifo_level == '0 && !half_vld_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    flush_done_d = (state_q == FLUSH) && (state_d == IDLE);
  end

  // Packer and FSM registers.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      half_q       <= '0;
      half_vld_q   <= 1'b0;
      overflow_q   <= 1'b0;
      flush_done_q <= 1'b0;
      state_q      <= IDLE;
    end else begin
      half_q       <= half_d;
      half_vld_q   <= half_vld_d;
      overflow_q   <= overflow_d;
      flush_done_q <= flush_done_d;
      state_q      <= state_d;
    end
  end

`ifdef RLE_PACK_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Dropped-word count: two words lost per rejected push, saturating.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) drop_cnt_d = (drop_cnt_q >= 16'hFFFE) ? 16'hFFFF : drop_cnt_q + 16'd2;
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) drop_cnt_q <= '0;
    else             drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_data   = fifo_rdata;
  assign out_valid  = !fifo_empty;
  assign level      = fifo_level;
  assign overflow   = overflow_q;
  assign flush_done = flush_done_q;

endmodule
